// File: rtl/mips_muldiv_unit_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit.
//   Data_Width     : default operand / HI / LO width
//   muldiv_op_t    : decoded operation presented with start
//   muldiv_state_t : control FSM states
package mips_muldiv_unit_pkg;

    localparam int unsigned Data_Width = 32;

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMthi  = 3'b100,
        OpMtlo  = 3'b101,
        OpRsv6  = 3'b110,
        OpRsv7  = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFinish
    } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Request/response bundle between the core and the multiply/divide unit.
//   master (core) : drives start, op, flush, rs_val, rt_val; observes busy, done, err, hi, lo
//   slave  (unit) : the reverse
interface mips_muldiv_unit_if
    import mips_muldiv_unit_pkg::*;
#(
    parameter int unsigned DW = Data_Width
);
    logic          start;
    muldiv_op_t    op;
    logic          flush;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    modport master (
        output start, op, flush, rs_val, rt_val,
        input  busy, done, err, hi, lo
    );

    modport slave (
        input  start, op, flush, rs_val, rt_val,
        output busy, done, err, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
//   div_mode : 1 = restoring divide step, 0 = shift-add multiply step
//              (port present only when MIPS_MULDIV_DIV_EN is defined)
//   acc      : current 2*DW accumulator {upper, lower}
//   opnd     : multiplicand (multiply) or divisor (divide)
//   acc_next : accumulator after this iteration
// Macro MIPS_MULDIV_DIV_EN: compiles in the divide step.
module muldiv_step #(
    parameter int unsigned DW = 32
) (
`ifdef MIPS_MULDIV_DIV_EN
    input  logic            div_mode,
`endif
    input  logic [2*DW-1:0] acc,
    input  logic [DW-1:0]   opnd,
    output logic [2*DW-1:0] acc_next
);
    // Upper half plus multiplicand; the carry becomes the new MSB after the shift.
    logic [DW:0] sum;
    assign sum = {1'b0, acc[2*DW-1:DW]} + {1'b0, opnd};

`ifdef MIPS_MULDIV_DIV_EN
    // Remainder after the left shift can need DW+1 bits.
    logic [DW:0]   rem_sh;
    logic          rem_ge;
    logic [DW-1:0] diff;
    assign rem_sh = acc[2*DW-1:DW-1];
    assign rem_ge = rem_sh >= {1'b0, opnd};
    // When rem_ge holds the true difference is below opnd, so DW bits suffice.
    assign diff   = rem_sh[DW-1:0] - opnd;
`endif

    always_comb begin
        acc_next = acc[0] ? {sum, acc[DW-1:1]} : {1'b0, acc[2*DW-1:1]};
`ifdef MIPS_MULDIV_DIV_EN
        if (div_mode) begin
            acc_next = rem_ge ? {diff, acc[DW-2:0], 1'b1}
                              : {rem_sh[DW-1:0], acc[DW-2:0], 1'b0};
        end
`endif
    end
endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit, one bit per cycle.
//   clk : core clock
//   rst : asynchronous active-low reset
//   bus : slave side of mips_muldiv_unit_if (start/op/flush/operands in,
//         busy/done/err/hi/lo out)
// Macro MIPS_MULDIV_DIV_EN: when undefined, DIV/DIVU are rejected with err.
module mips_muldiv_unit
    import mips_muldiv_unit_pkg::*;
#(
    parameter int unsigned DW = Data_Width
) (
    input  logic               clk,
    input  logic               rst,
    mips_muldiv_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(DW);

    muldiv_state_t   state_q;
    logic [2*DW-1:0] acc_q, acc_next, prod;
    logic [DW-1:0]   opnd_q, hi_q, lo_q, res_hi, res_lo;
    logic [CntW-1:0] cnt_q;
    logic            neg_q, done_q, err_q;
    logic            signed_op, rs_neg, rt_neg;
    logic [DW-1:0]   rs_abs, rt_abs;
`ifdef MIPS_MULDIV_DIV_EN
    logic            is_div_q, rem_neg_q, div_zero_q;
    logic [DW-1:0]   rs_raw_q;
`endif

    muldiv_step #(.DW(DW)) u_step (
`ifdef MIPS_MULDIV_DIV_EN
        .div_mode (is_div_q),
`endif
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_next)
    );

    // Signed ops iterate on magnitudes; the sign is reapplied in FINISH.
    always_comb begin
        signed_op = (bus.op == OpMult) || (bus.op == OpDiv);
        rs_neg    = signed_op && bus.rs_val[DW-1];
        rt_neg    = signed_op && bus.rt_val[DW-1];
        rs_abs    = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_abs    = rt_neg ? -bus.rt_val : bus.rt_val;
    end

    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        res_hi = prod[2*DW-1:DW];
        res_lo = prod[DW-1:0];
`ifdef MIPS_MULDIV_DIV_EN
        if (is_div_q) begin
            if (div_zero_q) begin
                res_hi = rs_raw_q;
                res_lo = '1;
            end else begin
                res_lo = neg_q ? -acc_q[DW-1:0] : acc_q[DW-1:0];
                res_hi = rem_neg_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
            is_div_q   <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            rs_raw_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // flush squashes a same-cycle start entirely
                    if (bus.start && !bus.flush) begin
                        case (bus.op)
                            OpMult, OpMultu: begin
                                opnd_q   <= rs_abs;
                                acc_q    <= {{DW{1'b0}}, rt_abs};
                                neg_q    <= rs_neg ^ rt_neg;
                                cnt_q    <= '0;
`ifdef MIPS_MULDIV_DIV_EN
                                is_div_q <= 1'b0;
`endif
                                state_q  <= StCalc;
                            end
`ifdef MIPS_MULDIV_DIV_EN
                            OpDiv, OpDivu: begin
                                opnd_q     <= rt_abs;
                                acc_q      <= {{DW{1'b0}}, rs_abs};
                                neg_q      <= rs_neg ^ rt_neg;
                                rem_neg_q  <= rs_neg;
                                div_zero_q <= (bus.rt_val == '0);
                                rs_raw_q   <= bus.rs_val;
                                cnt_q      <= '0;
                                is_div_q   <= 1'b1;
                                state_q    <= StCalc;
                            end
`endif
                            OpMthi:  hi_q  <= bus.rs_val;
                            OpMtlo:  lo_q  <= bus.rs_val;
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                StCalc: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntW'(DW - 1)) state_q <= StFinish;
                    end
                end
                StFinish: begin
                    if (!bus.flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every done/err pulse.
module tb_mips_muldiv_unit;
    import mips_muldiv_unit_pkg::*;

    localparam int unsigned DW = Data_Width;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mips_muldiv_unit_if #(.DW(DW)) bus ();

    mips_muldiv_unit #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        int unsigned   cyc;
        string         name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc      = 0;
    int          n_vec    = 0;
    int          n_bad    = 0;
    int          done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (bus.done || bus.err)) begin
            if (bus.done) done_cnt++;
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected pulse: done=%0b err=%0b, expected none", bus.done, bus.err);
            end else begin
                e = sb.pop_front();
                chk({e.name, " err"},  DW'(bus.err),  DW'(e.is_err));
                chk({e.name, " done"}, DW'(bus.done), DW'(!e.is_err));
                chk({e.name, " hi"},   bus.hi, e.hi);
                chk({e.name, " lo"},   bus.lo, e.lo);
                chk({e.name, " cycle"}, DW'(cyc), DW'(e.cyc));
            end
        end
    end

    task automatic drive_start(input muldiv_op_t op, input logic [DW-1:0] rs,
                               input logic [DW-1:0] rt);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        // operands are latched; scramble them to prove it
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
    endtask

    task automatic issue(input string name, input muldiv_op_t op, input logic [DW-1:0] rs,
                         input logic [DW-1:0] rt, input bit is_err,
                         input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        exp_t e;
        drive_start(op, rs, rt);
        e.is_err = is_err;
        e.hi     = hi;
        e.lo     = lo;
        e.cyc    = is_err ? cyc : cyc + DW + 1;
        e.name   = name;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
    endtask

    task automatic run(input string name, input muldiv_op_t op, input logic [DW-1:0] rs,
                       input logic [DW-1:0] rt, input bit is_err,
                       input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        issue(name, op, rs, rt, is_err, hi, lo);
        wait_idle(name);
    endtask

    initial begin
        int d0;
        bus.start  = 1'b0;
        bus.op     = OpMult;
        bus.flush  = 1'b0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset busy", DW'(bus.busy), '0);
        chk("reset done", DW'(bus.done), '0);
        chk("reset err",  DW'(bus.err),  '0);
        chk("reset hi",   bus.hi, '0);
        chk("reset lo",   bus.lo, '0);

        run("mult -1*2",      OpMult,  32'hFFFF_FFFF, 32'h2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("multu ffff*2",   OpMultu, 32'hFFFF_FFFF, 32'h2, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
        run("mult min*min",   OpMult,  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0);
        run("mult 7*-3",      OpMult,  32'h7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("multu x*16",     OpMultu, 32'h1234_5678, 32'h10, 1'b0, 32'h1, 32'h2345_6780);

        drive_start(OpMthi, 32'hCAFE_F00D, 32'h0);
        chk("mthi hi", bus.hi, 32'hCAFE_F00D);
        chk("mthi busy", DW'(bus.busy), '0);
        drive_start(OpMtlo, 32'h0BAD_BEEF, 32'h0);
        chk("mtlo lo", bus.lo, 32'h0BAD_BEEF);
        chk("mtlo hi kept", bus.hi, 32'hCAFE_F00D);

        run("rsv6", OpRsv6, 32'h1, 32'h1, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        run("rsv7", OpRsv7, 32'h1, 32'h1, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF);

`ifdef MIPS_MULDIV_DIV_EN
        run("div -7/2",      OpDiv,  32'hFFFF_FFF9, 32'h2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu 100/7",    OpDivu, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
        run("divu 5/0",      OpDivu, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF);
        run("div -7/0",      OpDiv,  32'hFFFF_FFF9, 32'd0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run("div min/-1",    OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
        run("div 7/-2",      OpDiv,  32'd7, 32'hFFFF_FFFE, 1'b0, 32'h1, 32'hFFFF_FFFD);
        run("divu big/3",    OpDivu, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h0, 32'h5555_5555);
`else
        issue("div disabled", OpDiv, 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        chk("div disabled busy", DW'(bus.busy), '0);
        wait_idle("div disabled");
        issue("divu disabled", OpDivu, 32'd100, 32'd7, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        chk("divu disabled busy", DW'(bus.busy), '0);
        wait_idle("divu disabled");
`endif

        // flush 10 cycles into a multiply: no result, no done
        drive_start(OpMthi, 32'h1234_5678, 32'h0);
        d0 = done_cnt;
        drive_start(OpMult, 32'd3, 32'd4);
        chk("mult busy", DW'(bus.busy), 32'h1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush busy", DW'(bus.busy), '0);
        chk("flush hi", bus.hi, 32'h1234_5678);
        repeat (40) @(posedge clk);
        chk("flush no done", DW'(done_cnt), DW'(d0));

        // asynchronous reset mid-CALC clears everything before the next edge
        drive_start(OpMtlo, 32'h7777_0000, 32'h0);
        drive_start(OpMultu, 32'd11, 32'd13);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst busy", DW'(bus.busy), '0);
        chk("rst hi", bus.hi, '0);
        chk("rst lo", bus.lo, '0);
        @(negedge clk);
        rst = 1'b1;

        // start while busy is ignored
        issue("multu 3*5", OpMultu, 32'd3, 32'd5, 1'b0, 32'h0, 32'd15);
        repeat (4) @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = OpMthi;
        bus.rs_val = 32'hDEAD_0000;
        @(negedge clk);
        bus.op     = OpMult;
        bus.rs_val = 32'd9;
        bus.rt_val = 32'd9;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_idle("multu 3*5");
        chk("busy start hi", bus.hi, 32'h0);

        // flush wins over a same-cycle start in IDLE
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.op     = OpMtlo;
        bus.rs_val = 32'h0000_AAAA;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        chk("flush+start lo", bus.lo, 32'd15);
        chk("flush+start busy", DW'(bus.busy), '0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
